f2h_reset_event_ctrl: RTL and testbench

Parametrised fabric-to-HPS reset and event controller that sits between user fabric logic and the HPS `f2h_*` conduits of the SoC system top. It turns raw fabric reset requests into correctly shaped, prioritised, rate-limited cold/warm/debug reset pulses. It then tracks the HPS handshake on `h2f_reset_n`, with a timeout. It also converts an N-wide bus of fabric event levels into stretched, edge-triggered STM hardware event pulses.

---
 rtl/f2h_reset_event_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_f2h_reset_event_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/f2h_reset_event_ctrl.sv
// Fabric-to-HPS reset/event controller: prioritised, shaped, rate-limited reset
// requests with HPS handshake tracking, plus stretched STM hardware event pulses.
module f2h_reset_event_ctrl #(
  parameter int N_EVENTS       = 28,
  parameter int STRETCH        = 4,
  parameter int PULSE_CYCLES   = 16,
  parameter int HOLDOFF_CYCLES = 64,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic                req_cold,
  input  logic                req_warm,
  input  logic                req_debug,
  input  logic [N_EVENTS-1:0] ev_in,
  input  logic                h2f_reset_n,
  input  logic                clear_status,
  output logic                f2h_cold_reset_req_reset_n,
  output logic                f2h_warm_reset_req_reset_n,
  output logic                f2h_debug_reset_req_reset_n,
  output logic [N_EVENTS-1:0] f2h_stm_hwevents,
  output logic                busy,
  output logic [1:0]          last_req,
  output logic                timeout
);

  localparam int PW   = $clog2(PULSE_CYCLES) + 1;
  localparam int HW   = $clog2(HOLDOFF_CYCLES) + 1;
  localparam int TW   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int SW   = $clog2(STRETCH) + 1;
  localparam int CW_A = (PW > HW) ? PW : HW;
  localparam int CW   = (CW_A > TW) ? CW_A : TW;

  localparam logic [CW-1:0] CNT_ZERO     = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [CW-1:0] PULSE_LAST   = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] HOLDOFF_LAST = CW'(HOLDOFF_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] EV_ZERO      = {SW{1'b0}};
  localparam logic [SW-1:0] EV_ONE       = SW'(1);
  localparam logic [SW-1:0] EV_LOAD      = SW'(STRETCH);

  localparam logic [1:0] REQ_NONE  = 2'b00;
  localparam logic [1:0] REQ_DEBUG = 2'b01;
  localparam logic [1:0] REQ_WARM  = 2'b10;
  localparam logic [1:0] REQ_COLD  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ASSERT    = 3'd1,
    S_WAIT_LOW  = 3'd2,
    S_WAIT_HIGH = 3'd3,
    S_HOLDOFF   = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    r_sel;
  logic [1:0]    w_sel_nxt;
  logic [1:0]    w_req_sel;
  logic          w_accept;
  logic          w_timeout_set;

  logic          r_sync1;
  logic          r_sync2;

  logic          r_cold_n;
  logic          r_warm_n;
  logic          r_debug_n;
  logic          r_busy;
  logic [1:0]    r_last_req;
  logic          r_timeout;
  logic          w_cold_n_nxt;
  logic          w_warm_n_nxt;
  logic          w_debug_n_nxt;
  logic          w_busy_nxt;
  logic [1:0]    w_last_req_nxt;
  logic          w_timeout_nxt;

  logic [N_EVENTS-1:0] r_ev_hist;
  logic [N_EVENTS-1:0] r_ev_out;
  logic [SW-1:0]       r_ev_cnt     [N_EVENTS];
  logic [SW-1:0]       w_ev_cnt_nxt [N_EVENTS];

  // Two-flop synchroniser for the asynchronous HPS reset; idles high.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= h2f_reset_n;
      r_sync2 <= r_sync1;
    end
  end

  // Request priority, FSM next state and next values of the registered outputs.
  always_comb begin
    w_req_sel     = REQ_NONE;
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_sel_nxt     = r_sel;
    w_accept      = 1'b0;
    w_timeout_set = 1'b0;

    if (req_cold) begin
      w_req_sel = REQ_COLD;
    end else if (req_warm) begin
      w_req_sel = REQ_WARM;
    end else if (req_debug) begin
      w_req_sel = REQ_DEBUG;
    end else begin
      w_req_sel = REQ_NONE;
    end

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = CNT_ZERO;
        if (w_req_sel != REQ_NONE) begin
          w_accept    = 1'b1;
          w_sel_nxt   = w_req_sel;
          w_state_nxt = S_ASSERT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ASSERT: begin
        if (r_cnt == PULSE_LAST) begin
          w_cnt_nxt   = CNT_ZERO;
          // The HPS never resets the fabric on a debug reset, so skip the handshake.
          w_state_nxt = (r_sel == REQ_DEBUG) ? S_HOLDOFF : S_WAIT_LOW;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_WAIT_LOW: begin
        if (r_cnt == TIMEOUT_LAST) begin
          w_timeout_set = 1'b1;
          w_cnt_nxt     = CNT_ZERO;
          w_state_nxt   = S_HOLDOFF;
        end else if (!r_sync2) begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
          w_state_nxt = S_WAIT_HIGH;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_WAIT_HIGH: begin
        // A completed handshake on the last allowed cycle beats the timeout.
        if (r_sync2) begin
          w_cnt_nxt   = CNT_ZERO;
          w_state_nxt = S_HOLDOFF;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_timeout_set = 1'b1;
          w_cnt_nxt     = CNT_ZERO;
          w_state_nxt   = S_HOLDOFF;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_HOLDOFF: begin
        if (r_cnt == HOLDOFF_LAST) begin
          w_cnt_nxt   = CNT_ZERO;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_cnt_nxt   = CNT_ZERO;
        w_state_nxt = S_IDLE;
      end
    endcase

    w_cold_n_nxt  = !((w_state_nxt == S_ASSERT) && (w_sel_nxt == REQ_COLD));
    w_warm_n_nxt  = !((w_state_nxt == S_ASSERT) && (w_sel_nxt == REQ_WARM));
    w_debug_n_nxt = !((w_state_nxt == S_ASSERT) && (w_sel_nxt == REQ_DEBUG));
    w_busy_nxt    = (w_state_nxt != S_IDLE);

    if (w_accept) begin
      w_last_req_nxt = w_req_sel;
    end else if (clear_status) begin
      w_last_req_nxt = REQ_NONE;
    end else begin
      w_last_req_nxt = r_last_req;
    end

    if (w_timeout_set) begin
      w_timeout_nxt = 1'b1;
    end else if (clear_status) begin
      w_timeout_nxt = 1'b0;
    end else begin
      w_timeout_nxt = r_timeout;
    end
  end

  // FSM state, shared phase counter and registered control/status outputs.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= CNT_ZERO;
      r_sel      <= REQ_NONE;
      r_cold_n   <= 1'b1;
      r_warm_n   <= 1'b1;
      r_debug_n  <= 1'b1;
      r_busy     <= 1'b0;
      r_last_req <= REQ_NONE;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sel      <= w_sel_nxt;
      r_cold_n   <= w_cold_n_nxt;
      r_warm_n   <= w_warm_n_nxt;
      r_debug_n  <= w_debug_n_nxt;
      r_busy     <= w_busy_nxt;
      r_last_req <= w_last_req_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  // Per-bit stretch counters: a rising edge reloads, otherwise count down to zero.
  always_comb begin
    for (int i = 0; i < N_EVENTS; i++) begin
      if (ev_in[i] && !r_ev_hist[i]) begin
        w_ev_cnt_nxt[i] = EV_LOAD;
      end else if (r_ev_cnt[i] != EV_ZERO) begin
        w_ev_cnt_nxt[i] = r_ev_cnt[i] - EV_ONE;
      end else begin
        w_ev_cnt_nxt[i] = EV_ZERO;
      end
    end
  end

  // Event history (all ones at reset so already-high inputs never fire) and outputs.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_ev_hist <= {N_EVENTS{1'b1}};
      r_ev_out  <= {N_EVENTS{1'b0}};
      for (int i = 0; i < N_EVENTS; i++) begin
        r_ev_cnt[i] <= EV_ZERO;
      end
    end else begin
      r_ev_hist <= ev_in;
      for (int i = 0; i < N_EVENTS; i++) begin
        r_ev_cnt[i] <= w_ev_cnt_nxt[i];
        r_ev_out[i] <= (r_ev_cnt[i] != EV_ZERO);
      end
    end
  end

  assign f2h_cold_reset_req_reset_n  = r_cold_n;
  assign f2h_warm_reset_req_reset_n  = r_warm_n;
  assign f2h_debug_reset_req_reset_n = r_debug_n;
  assign f2h_stm_hwevents            = r_ev_out;
  assign busy                        = r_busy;
  assign last_req                    = r_last_req;
  assign timeout                     = r_timeout;

endmodule

// File: tb/tb_f2h_reset_event_ctrl.sv
// Bench for f2h_reset_event_ctrl: directed scenarios with literal timing checks,
// then random traffic, all compared every cycle against a timestamp-based model.
module tb_f2h_reset_event_ctrl;
  localparam int N = 28;
  localparam int S = 4;
  localparam int P = 16;
  localparam int H = 64;
  localparam int T = 100;
  localparam int NONE = -100000;

  logic clk = 1'b0;
  logic reset_reset;
  logic req_cold, req_warm, req_debug;
  logic [N-1:0] ev_in;
  logic h2f_reset_n;
  logic clear_status;
  logic cold_n, warm_n, debug_n;
  logic [N-1:0] hwev;
  logic busy;
  logic [1:0] last_req;
  logic timeout;

  f2h_reset_event_ctrl #(
    .N_EVENTS(N), .STRETCH(S), .PULSE_CYCLES(P), .HOLDOFF_CYCLES(H), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_clk(clk),
    .reset_reset(reset_reset),
    .req_cold(req_cold),
    .req_warm(req_warm),
    .req_debug(req_debug),
    .ev_in(ev_in),
    .h2f_reset_n(h2f_reset_n),
    .clear_status(clear_status),
    .f2h_cold_reset_req_reset_n(cold_n),
    .f2h_warm_reset_req_reset_n(warm_n),
    .f2h_debug_reset_req_reset_n(debug_n),
    .f2h_stm_hwevents(hwev),
    .busy(busy),
    .last_req(last_req),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model: one transaction described by absolute cycle stamps.
  bit       seen_rst = 1'b0;
  int       m_rst_at = 0;
  bit       m_active = 1'b0;
  logic [1:0] m_sel = 2'b00;
  int       m_acc = NONE, m_wait = NONE, m_low = -1, m_hold = -1;
  bit       m_to = 1'b0;
  logic [1:0] m_last = 2'b00;
  bit       h_log [int];
  logic [N-1:0] m_hist = '1;
  int       r1 [N];
  int       r2 [N];
  int       m_t;
  bit       m_idle, m_s, m_pulse;
  logic [N-1:0] e_ev;

  always @(negedge clk) begin
    int c;
    c = cyc;
    if (seen_rst) begin
      m_idle  = !m_active || (m_hold >= 0 && c >= m_hold + H);
      m_pulse = m_active && (c >= m_acc + 1) && (c <= m_acc + P);
      for (int i = 0; i < N; i++) begin
        m_t = (r1[i] <= c - 2) ? r1[i] : r2[i];
        e_ev[i] = ((c - m_t) >= 2) && ((c - m_t) <= S + 1);
      end
      chk("cold_n",  64'(cold_n),  64'(!(m_pulse && m_sel == 2'b11)));
      chk("warm_n",  64'(warm_n),  64'(!(m_pulse && m_sel == 2'b10)));
      chk("debug_n", 64'(debug_n), 64'(!(m_pulse && m_sel == 2'b01)));
      chk("busy",    64'(busy),    64'(!m_idle));
      chk("last_req", 64'(last_req), 64'(m_last));
      chk("timeout", 64'(timeout), 64'(m_to));
      chk("hwevents", 64'(hwev), 64'(e_ev));
    end

    h_log[c] = h2f_reset_n;
    if (reset_reset) begin
      seen_rst = 1'b1;
      m_rst_at = c;
      m_active = 1'b0;
      m_hold   = -1;
      m_to     = 1'b0;
      m_last   = 2'b00;
      m_hist   = '1;
      for (int i = 0; i < N; i++) begin
        r1[i] = NONE;
        r2[i] = NONE;
      end
    end else if (seen_rst) begin
      for (int i = 0; i < N; i++) begin
        if (ev_in[i] && !m_hist[i]) begin
          r2[i] = r1[i];
          r1[i] = c;
        end
      end
      m_hist = ev_in;
      if (clear_status) begin
        m_to   = 1'b0;
        m_last = 2'b00;
      end
      m_idle = !m_active || (m_hold >= 0 && c >= m_hold + H);
      if (!m_idle && m_sel != 2'b01 && m_hold < 0 && c >= m_wait) begin
        m_s = (c - 2 > m_rst_at) ? h_log[c - 2] : 1'b1;
        if (m_low < 0) begin
          if (!m_s) m_low = c;
        end else if (c > m_low && m_s) begin
          m_hold = c + 1;
        end
        if (m_hold < 0 && c == m_wait + T - 1) begin
          m_hold = c + 1;
          m_to   = 1'b1;
        end
      end
      if (m_idle) begin
        m_active = 1'b0;
        if (req_cold || req_warm || req_debug) begin
          m_sel    = req_cold ? 2'b11 : (req_warm ? 2'b10 : 2'b01);
          m_active = 1'b1;
          m_acc    = c;
          m_wait   = c + P + 1;
          m_low    = -1;
          m_hold   = (m_sel == 2'b01) ? c + P + 1 : -1;
          m_last   = m_sel;
        end
      end
    end
  end

  initial begin
    int t0, t1, t2, te, h_rise, n, n_bad, ev27;
    int low_left;
    logic [10:0] v;
    logic [N-1:0] flip;

    reset_reset = 1'b1;
    req_cold = 1'b0; req_warm = 1'b0; req_debug = 1'b0;
    ev_in = '0;
    ev_in[27] = 1'b1;
    h2f_reset_n = 1'b1;
    clear_status = 1'b0;

    tick(3);
    chk("rst_cold_n", 64'(cold_n), 64'(1));
    chk("rst_debug_n", 64'(debug_n), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_last", 64'(last_req), 64'(0));
    chk("rst_hwev", 64'(hwev), 64'(0));
    reset_reset = 1'b0;

    // Cold request with a full HPS handshake.
    tick(2);
    req_cold = 1'b1; t0 = cyc;
    tick(1);
    req_cold = 1'b0;
    chk("cold_first_low", 64'(cold_n), 64'(0));
    chk("cold_busy", 64'(busy), 64'(1));
    chk("cold_last", 64'(last_req), 64'(2'b11));
    n = 0;
    while (cold_n == 1'b0 && n < 100) begin n++; tick(1); end
    chk("cold_pulse_len", 64'(n), 64'(16));
    tick(10);
    h2f_reset_n = 1'b0;
    tick(20);
    h2f_reset_n = 1'b1; h_rise = cyc;
    n = 0;
    while (busy && n < 500) begin n++; tick(1); end
    chk("cold_busy_fall", 64'(cyc), 64'(h_rise + 3 + H));
    chk("cold_no_timeout", 64'(timeout), 64'(0));
    clear_status = 1'b1; tick(1); clear_status = 1'b0;
    chk("clear_last", 64'(last_req), 64'(0));

    // Warm+debug together, a cold during ASSERT, then a handshake timeout.
    tick(1);
    req_warm = 1'b1; req_debug = 1'b1; t1 = cyc;
    tick(1);
    req_warm = 1'b0; req_debug = 1'b0;
    chk("warm_low", 64'(warm_n), 64'(0));
    chk("warm_last", 64'(last_req), 64'(2'b10));
    tick(2);
    req_cold = 1'b1;
    tick(1);
    req_cold = 1'b0;
    n_bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (!cold_n || !debug_n) n_bad++;
      tick(1);
    end
    chk("unselected_quiet", 64'(n_bad), 64'(0));
    n = 0;
    while (!timeout && n < 400) begin n++; tick(1); end
    chk("timeout_rise", 64'(cyc), 64'(t1 + 1 + P + T));
    chk("timeout_last", 64'(last_req), 64'(2'b10));
    n = 0;
    while (busy && n < 400) begin n++; tick(1); end
    chk("timeout_idle", 64'(cyc), 64'(t1 + 1 + P + T + H));
    clear_status = 1'b1; tick(1); clear_status = 1'b0;
    chk("clear_timeout", 64'(timeout), 64'(0));
    chk("clear_last2", 64'(last_req), 64'(0));

    // Event stretch with a re-trigger; bit 27 has been high since reset.
    tick(2);
    te = cyc; ev27 = 0;
    for (int k = 0; k < 11; k++) begin
      ev_in[0] = (k == 0 || k == 2) ? 1'b1 : 1'b0;
      v[k] = hwev[0];
      if (hwev[27]) ev27++;
      tick(1);
    end
    chk("ev0_pattern", 64'(v), 64'(11'h0FC));
    chk("ev27_silent", 64'(ev27), 64'(0));

    // Reset in the 5th ASSERT cycle, then an immediate new request.
    req_debug = 1'b1; t2 = cyc;
    tick(1);
    req_debug = 1'b0;
    tick(4);
    reset_reset = 1'b1;
    tick(1);
    reset_reset = 1'b0;
    chk("mid_rst_debug_n", 64'(debug_n), 64'(1));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_cyc", 64'(cyc), 64'(t2 + 6));
    req_warm = 1'b1;
    tick(1);
    req_warm = 1'b0;
    chk("post_rst_warm", 64'(warm_n), 64'(0));
    chk("post_rst_last", 64'(last_req), 64'(2'b10));
    n = 0;
    while (busy && n < 400) begin n++; tick(1); end

    // Random traffic.
    low_left = 0;
    for (int k = 0; k < 6000; k++) begin
      reset_reset = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 29) == 0) begin
        req_cold  = 1'($urandom_range(0, 1));
        req_warm  = 1'($urandom_range(0, 1));
        req_debug = 1'($urandom_range(0, 1));
      end else begin
        req_cold = 1'b0; req_warm = 1'b0; req_debug = 1'b0;
      end
      clear_status = ($urandom_range(0, 49) == 0);
      if (low_left > 0) begin
        low_left--;
        h2f_reset_n = (low_left == 0);
      end else if ($urandom_range(0, 39) == 0) begin
        low_left = $urandom_range(1, 30);
        h2f_reset_n = 1'b0;
      end else begin
        h2f_reset_n = 1'b1;
      end
      for (int i = 0; i < N; i++) flip[i] = ($urandom_range(0, 3) == 0);
      ev_in = ev_in ^ flip;
      tick(1);
    end
    reset_reset = 1'b0;
    req_cold = 1'b0; req_warm = 1'b0; req_debug = 1'b0;
    clear_status = 1'b0;
    tick(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
